// File: rtl/ysyx_25060173_mem_arbiter_pkg.sv
// Shared types for the IF/LS memory arbiter: FSM state encoding, grant IDs, default widths.
package ysyx_25060173_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } gnt_e;

endpackage

// File: rtl/ysyx_25060173_mem_arbiter_if.sv
// Bundle of IF, LS and memory-side handshake signals; slave is the arbiter, master the environment.
interface ysyx_25060173_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;

    logic                ls_req_valid;
    logic                ls_req_ready;
    logic [ADDR_W-1:0]   ls_req_addr;
    logic                ls_req_wen;
    logic [DATA_W-1:0]   ls_req_wdata;
    logic [DATA_W/8-1:0] ls_req_wmask;
    logic                ls_resp_valid;
    logic [DATA_W-1:0]   ls_resp_data;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_wen;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic [DATA_W/8-1:0] mem_req_wmask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_resp_data;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        output ls_req_ready, ls_resp_valid, ls_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        input  ls_req_ready, ls_resp_valid, ls_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/ysyx_25060173_arb_pick.sv
// Combinational 2-way picker. Fixed LS > IF priority by default;
// YSYX_25060173_MEM_ARB_RR_EN selects round-robin against last_grant.
module ysyx_25060173_arb_pick
    import ysyx_25060173_mem_arbiter_pkg::*;
(
    input  logic if_valid,
    input  logic ls_valid,
    input  gnt_e last_grant,
    output gnt_e grant,
    output logic any_valid
);

    assign any_valid = if_valid | ls_valid;

`ifdef YSYX_25060173_MEM_ARB_RR_EN
    always_comb begin
        grant = GNT_IF;
        if (if_valid && ls_valid) begin
            grant = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
        end else if (ls_valid) begin
            grant = GNT_LS;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = ls_valid ? GNT_LS : GNT_IF;
`endif

endmodule

// File: rtl/ysyx_25060173_mem_arbiter.sv
// Shares one memory port between IF and LS, one transaction in flight.
// Arbitration policy is selected by YSYX_25060173_MEM_ARB_RR_EN (see ysyx_25060173_arb_pick).
module ysyx_25060173_mem_arbiter
    import ysyx_25060173_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic                            clk,
    input logic                            rst,
    ysyx_25060173_mem_arbiter_if.slave     bus
);

    arb_state_e          state_q, state_d;
    gnt_e                owner_q, owner_d;
    gnt_e                last_grant_q, last_grant_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;

    gnt_e gnt;
    logic any_valid;
    logic accept;
    logic resp_fire;

    ysyx_25060173_arb_pick u_pick (
        .if_valid   (bus.if_req_valid),
        .ls_valid   (bus.ls_req_valid),
        .last_grant (last_grant_q),
        .grant      (gnt),
        .any_valid  (any_valid)
    );

    // Readies and responses are held low while rst is asserted so nothing leaks mid-reset.
    assign accept           = !rst && (state_q == IDLE) && any_valid;
    assign bus.ls_req_ready = accept && (gnt == GNT_LS);
    assign bus.if_req_ready = accept && (gnt == GNT_IF);

    assign resp_fire = !rst && bus.mem_resp_valid &&
                       ((state_q == WAIT) || ((state_q == REQ) && bus.mem_req_ready));

    assign bus.if_resp_valid = resp_fire && (owner_q == GNT_IF);
    assign bus.ls_resp_valid = resp_fire && (owner_q == GNT_LS);
    assign bus.if_resp_data  = bus.if_resp_valid ? bus.mem_resp_data : '0;
    assign bus.ls_resp_data  = bus.ls_resp_valid ? bus.mem_resp_data : '0;

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        mem_req_valid_d = mem_req_valid_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d         = gnt;
                    last_grant_d    = gnt;
                    state_d         = REQ;
                    mem_req_valid_d = 1'b1;
                    if (gnt == GNT_LS) begin
                        addr_d  = bus.ls_req_addr;
                        wen_d   = bus.ls_req_wen;
                        wdata_d = bus.ls_req_wdata;
                        wmask_d = bus.ls_req_wen ? bus.ls_req_wmask : '0;
                    end else begin
                        addr_d  = bus.if_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    // Zero-latency memory completes in the accept cycle and skips WAIT.
                    state_d = bus.mem_resp_valid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d         = IDLE;
                mem_req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= GNT_IF;
            last_grant_q    <= GNT_IF;
            mem_req_valid_q <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            mem_req_valid_q <= mem_req_valid_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25060173_mem_arbiter.sv
// Directed bench for the IF/LS memory arbiter; round-robin expectations apply when
// YSYX_25060173_MEM_ARB_RR_EN is defined.
module tb_ysyx_25060173_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ysyx_25060173_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arb_bus ();

    ysyx_25060173_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h, want %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        arb_bus.if_req_valid   = 1'b0;
        arb_bus.if_req_addr    = '0;
        arb_bus.ls_req_valid   = 1'b0;
        arb_bus.ls_req_addr    = '0;
        arb_bus.ls_req_wen     = 1'b0;
        arb_bus.ls_req_wdata   = '0;
        arb_bus.ls_req_wmask   = '0;
        arb_bus.mem_req_ready  = 1'b0;
        arb_bus.mem_resp_valid = 1'b0;
        arb_bus.mem_resp_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic exp_ls;
        n_checks = 0;
        n_pass   = 0;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Reset state, with requests and a stray response present
        arb_bus.if_req_valid   = 1'b1;
        arb_bus.ls_req_valid   = 1'b1;
        arb_bus.mem_resp_valid = 1'b1;
        settle();
        check_val("rst_if_ready", arb_bus.if_req_ready, 0);
        check_val("rst_ls_ready", arb_bus.ls_req_ready, 0);
        check_val("rst_mem_valid", arb_bus.mem_req_valid, 0);
        check_val("rst_mem_addr", arb_bus.mem_req_addr, 0);
        check_val("rst_mem_wmask", arb_bus.mem_req_wmask, 0);
        check_val("rst_ls_resp", arb_bus.ls_resp_valid, 0);
        check_val("rst_if_resp", arb_bus.if_resp_valid, 0);
        tick();
        clear_inputs();

        // Reset mid-REQ: LS store accepted, then reset
        rst = 1'b0;
        arb_bus.ls_req_valid = 1'b1;
        arb_bus.ls_req_wen   = 1'b1;
        arb_bus.ls_req_addr  = 32'h8000_0010;
        arb_bus.ls_req_wdata = 32'h1234_5678;
        arb_bus.ls_req_wmask = 4'hF;
        settle();
        check_val("mid_ls_ready", arb_bus.ls_req_ready, 1);
        check_val("mid_if_ready", arb_bus.if_req_ready, 0);
        tick();
        clear_inputs();
        rst = 1'b1;
        settle();
        check_val("mid_req_valid", arb_bus.mem_req_valid, 1);
        check_val("mid_req_addr", arb_bus.mem_req_addr, 32'h8000_0010);
        tick();
        rst = 1'b0;
        arb_bus.mem_resp_valid = 1'b1;
        arb_bus.mem_resp_data  = 32'hAAAA_5555;
        settle();
        check_val("mid_ls_resp", arb_bus.ls_resp_valid, 0);
        check_val("mid_ls_data", arb_bus.ls_resp_data, 0);
        check_val("mid_post_valid", arb_bus.mem_req_valid, 0);
        check_val("mid_post_addr", arb_bus.mem_req_addr, 0);
        check_val("mid_post_wen", arb_bus.mem_req_wen, 0);
        tick();
        clear_inputs();

        // IF alone, memory latency 2
        arb_bus.if_req_valid  = 1'b1;
        arb_bus.if_req_addr   = 32'h8000_0000;
        arb_bus.mem_req_ready = 1'b1;
        settle();
        check_val("if_idle_ready", arb_bus.if_req_ready, 1);
        check_val("if_ls_ready", arb_bus.ls_req_ready, 0);
        tick();
        arb_bus.if_req_valid = 1'b0;
        settle();
        check_val("if_req_valid", arb_bus.mem_req_valid, 1);
        check_val("if_req_addr", arb_bus.mem_req_addr, 32'h8000_0000);
        check_val("if_req_wen", arb_bus.mem_req_wen, 0);
        check_val("if_req_wmask", arb_bus.mem_req_wmask, 0);
        check_val("if_resp_early", arb_bus.if_resp_valid, 0);
        tick();
        settle();
        check_val("if_wait_valid", arb_bus.mem_req_valid, 0);
        check_val("if_wait_resp", arb_bus.if_resp_valid, 0);
        tick();
        arb_bus.mem_resp_valid = 1'b1;
        arb_bus.mem_resp_data  = 32'h0010_0073;
        settle();
        check_val("if_resp_valid", arb_bus.if_resp_valid, 1);
        check_val("if_resp_data", arb_bus.if_resp_data, 32'h0010_0073);
        check_val("if_ls_resp", arb_bus.ls_resp_valid, 0);
        check_val("if_ls_data", arb_bus.ls_resp_data, 0);
        tick();
        arb_bus.mem_resp_valid = 1'b0;
        settle();
        check_val("if_resp_pulse", arb_bus.if_resp_valid, 0);
        check_val("if_resp_zero", arb_bus.if_resp_data, 0);
        tick();

        // Simultaneous valids: LS first, IF one cycle after the LS response
        arb_bus.if_req_valid = 1'b1;
        arb_bus.if_req_addr  = 32'h8000_0004;
        arb_bus.ls_req_valid = 1'b1;
        arb_bus.ls_req_wen   = 1'b0;
        arb_bus.ls_req_addr  = 32'h8000_1000;
        arb_bus.ls_req_wmask = 4'hF;
        settle();
        check_val("sim_ls_ready", arb_bus.ls_req_ready, 1);
        check_val("sim_if_ready", arb_bus.if_req_ready, 0);
        tick();
        arb_bus.ls_req_valid = 1'b0;
        settle();
        check_val("sim_ls_addr", arb_bus.mem_req_addr, 32'h8000_1000);
        check_val("sim_ld_wen", arb_bus.mem_req_wen, 0);
        check_val("sim_ld_wmask", arb_bus.mem_req_wmask, 0);
        check_val("sim_if_blocked", arb_bus.if_req_ready, 0);
        tick();
        arb_bus.mem_resp_valid = 1'b1;
        arb_bus.mem_resp_data  = 32'hCAFE_F00D;
        settle();
        check_val("sim_ls_resp", arb_bus.ls_resp_valid, 1);
        check_val("sim_ls_data", arb_bus.ls_resp_data, 32'hCAFE_F00D);
        check_val("sim_if_resp", arb_bus.if_resp_valid, 0);
        check_val("sim_if_wait", arb_bus.if_req_ready, 0);
        tick();
        arb_bus.mem_resp_valid = 1'b0;
        settle();
        check_val("sim_if_grant", arb_bus.if_req_ready, 1);
        tick();
        arb_bus.if_req_valid = 1'b0;
        settle();
        check_val("sim_if_addr", arb_bus.mem_req_addr, 32'h8000_0004);
        tick();
        arb_bus.mem_resp_valid = 1'b1;
        arb_bus.mem_resp_data  = 32'h0000_0013;
        settle();
        check_val("sim_if_data", arb_bus.if_resp_data, 32'h0000_0013);
        tick();
        clear_inputs();

        // Backpressure on a store
        arb_bus.ls_req_valid = 1'b1;
        arb_bus.ls_req_wen   = 1'b1;
        arb_bus.ls_req_addr  = 32'h8000_2000;
        arb_bus.ls_req_wdata = 32'hDEAD_BEEF;
        arb_bus.ls_req_wmask = 4'hF;
        settle();
        check_val("bp_ls_ready", arb_bus.ls_req_ready, 1);
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            arb_bus.mem_req_ready = (i == 3);
            settle();
            check_val("bp_valid", arb_bus.mem_req_valid, 1);
            check_val("bp_addr", arb_bus.mem_req_addr, 32'h8000_2000);
            check_val("bp_wen", arb_bus.mem_req_wen, 1);
            check_val("bp_wdata", arb_bus.mem_req_wdata, 32'hDEAD_BEEF);
            check_val("bp_wmask", arb_bus.mem_req_wmask, 4'hF);
            check_val("bp_no_resp", arb_bus.ls_resp_valid, 0);
            tick();
        end
        arb_bus.mem_resp_valid = 1'b1;
        arb_bus.mem_resp_data  = '0;
        settle();
        check_val("bp_resp", arb_bus.ls_resp_valid, 1);
        check_val("bp_resp_data", arb_bus.ls_resp_data, 0);
        check_val("bp_wait_valid", arb_bus.mem_req_valid, 0);
        tick();
        clear_inputs();

        // Zero-latency memory and a stray response in IDLE
        arb_bus.if_req_valid  = 1'b1;
        arb_bus.if_req_addr   = 32'h8000_0008;
        arb_bus.mem_req_ready = 1'b1;
        settle();
        check_val("zl_if_ready", arb_bus.if_req_ready, 1);
        tick();
        arb_bus.if_req_valid   = 1'b0;
        arb_bus.mem_resp_valid = 1'b1;
        arb_bus.mem_resp_data  = 32'h1122_3344;
        settle();
        check_val("zl_resp", arb_bus.if_resp_valid, 1);
        check_val("zl_data", arb_bus.if_resp_data, 32'h1122_3344);
        tick();
        arb_bus.mem_resp_data = 32'h0000_0055;
        settle();
        check_val("zl_stray_if", arb_bus.if_resp_valid, 0);
        check_val("zl_stray_ls", arb_bus.ls_resp_valid, 0);
        check_val("zl_stray_data", arb_bus.if_resp_data, 0);
        check_val("zl_idle_valid", arb_bus.mem_req_valid, 0);
        tick();
        arb_bus.mem_resp_valid = 1'b0;
        arb_bus.ls_req_valid   = 1'b1;
        settle();
        check_val("zl_idle_ready", arb_bus.ls_req_ready, 1);
        arb_bus.ls_req_valid = 1'b0;
        tick();
        clear_inputs();

        // Both valids held for 4 zero-latency transactions from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        arb_bus.if_req_valid   = 1'b1;
        arb_bus.if_req_addr    = 32'h8000_000C;
        arb_bus.ls_req_valid   = 1'b1;
        arb_bus.ls_req_addr    = 32'h8000_3000;
        arb_bus.mem_req_ready  = 1'b1;
        arb_bus.mem_resp_valid = 1'b1;
        arb_bus.mem_resp_data  = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_25060173_MEM_ARB_RR_EN
            exp_ls = (i % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            settle();
            check_val("arb_ls_ready", arb_bus.ls_req_ready, exp_ls);
            check_val("arb_if_ready", arb_bus.if_req_ready, !exp_ls);
            tick();
            settle();
            check_val("arb_addr", arb_bus.mem_req_addr, exp_ls ? 32'h8000_3000 : 32'h8000_000C);
            check_val("arb_ls_resp", arb_bus.ls_resp_valid, exp_ls);
            check_val("arb_if_resp", arb_bus.if_resp_valid, !exp_ls);
            tick();
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
